// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB completion arbiter: register/ROB index widths,
// lane count, source indices and the pointer-width helper.
package cdb_arbiter_pkg;

    localparam int PRF_IDX = 6;
    localparam int ROB_IDX = 5;
    localparam int SCALAR  = 2;
    localparam int XLEN    = 64;

    localparam int SRC_ALU0  = 0;
    localparam int SRC_ALU1  = 1;
    localparam int SRC_MULT0 = 2;
    localparam int SRC_MULT1 = 3;
    localparam int SRC_MEM0  = 4;
    localparam int SRC_MEM1  = 5;
    localparam int NSRC_ALL  = 6;

    // Width of an index over n sources; never collapses to zero bits.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Completion-source and CDB broadcast bundle between the functional units,
// the arbiter, and the reservation stations / ROB.
interface cdb_arbiter_if #(
    parameter int NSRC = 6,
    parameter int NCDB = cdb_arbiter_pkg::SCALAR
);
    import cdb_arbiter_pkg::*;

    localparam int PTR_W = ptr_width(NSRC);

    // Handshake: a completion on source i transfers at the rising edge where
    // fu_valid[i] & fu_free[i] & ~squash; an unaccepted request must be held
    // by the source. cdb_valid is a one-cycle broadcast pulse, no backpressure.
    logic [NSRC-1:0]         fu_valid;
    logic [NSRC*PRF_IDX-1:0] fu_tag;
    logic [NSRC*ROB_IDX-1:0] fu_rob_idx;
    logic [NSRC*XLEN-1:0]    fu_value;
    logic                    squash;
    logic [NSRC-1:0]         fu_free;

    logic [NCDB-1:0]         cdb_valid;
    logic [NCDB*PRF_IDX-1:0] cdb_tag;
    logic [NCDB*ROB_IDX-1:0] cdb_rob_idx;
    logic [NCDB*XLEN-1:0]    cdb_value;

    // Round-robin start pointer, exposed for observation.
    logic [PTR_W-1:0]        rr_ptr;

    modport master (
        output fu_valid, fu_tag, fu_rob_idx, fu_value, squash,
        input  fu_free, cdb_valid, cdb_tag, cdb_rob_idx, cdb_value, rr_ptr
    );

    modport slave (
        input  fu_valid, fu_tag, fu_rob_idx, fu_value, squash,
        output fu_free, cdb_valid, cdb_tag, cdb_rob_idx, cdb_value, rr_ptr
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Find-first-set over an N-bit mask, scanning upward from a start index and
// wrapping from N-1 back to 0. Reports one-hot winner, its index and a found flag.
module rr_pick #(
    parameter int N  = 6,
    parameter int PW = 3
) (
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] start,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          found
);

    localparam logic [PW:0] N_W = (PW+1)'(N);

    logic [PW:0]   pos;
    logic [PW-1:0] j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = '0;
        j      = '0;
        for (int k = 0; k < N; k++) begin
            // start < N and k < N, so one subtraction is enough to wrap
            pos = {1'b0, start} + (PW+1)'(k);
            if (pos >= N_W) begin
                pos = pos - N_W;
            end
            j = pos[PW-1:0];
            if (!found && mask[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = j;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per FU completion source,
// round-robin grant of up to NCDB held entries per cycle onto registered lanes.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NSRC = 6,
    parameter int NCDB = SCALAR
) (
    input  logic          clk,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);

    localparam int PTR_W = ptr_width(NSRC);

    logic [NSRC-1:0]    hv;
    logic [PRF_IDX-1:0] h_tag [NSRC];
    logic [ROB_IDX-1:0] h_rob [NSRC];
    logic [XLEN-1:0]    h_val [NSRC];

    logic [NSRC-1:0]    grant;
    logic [NSRC-1:0]    capture;
    logic [NSRC-1:0]    fu_free;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   next_ptr;
    logic [PTR_W-1:0]   last_idx;
    logic               any_grant;

    logic [NSRC-1:0]    lane_mask   [NCDB];
    logic [NSRC-1:0]    lane_onehot [NCDB];
    logic [PTR_W-1:0]   lane_idx    [NCDB];
    logic [NCDB-1:0]    lane_found;

    logic [NCDB-1:0]         cdb_valid_q;
    logic [NCDB*PRF_IDX-1:0] cdb_tag_q;
    logic [NCDB*ROB_IDX-1:0] cdb_rob_q;
    logic [NCDB*XLEN-1:0]    cdb_value_q;

    // A source being granted this cycle may refill its holding register.
    assign fu_free = ~hv | grant;
    assign capture = bus.fu_valid & fu_free & {NSRC{~bus.squash}};

    // Each lane searches from the same start; later lanes skip earlier winners,
    // so lane order follows round-robin order and no source appears twice.
    for (genvar l = 0; l < NCDB; l++) begin : g_lane
        if (l == 0) begin : g_first
            assign lane_mask[l] = bus.squash ? '0 : hv;
        end else begin : g_rest
            assign lane_mask[l] = lane_mask[l-1] & ~lane_onehot[l-1];
        end

        rr_pick #(
            .N  (NSRC),
            .PW (PTR_W)
        ) u_pick (
            .mask   (lane_mask[l]),
            .start  (rr_ptr),
            .onehot (lane_onehot[l]),
            .idx    (lane_idx[l]),
            .found  (lane_found[l])
        );
    end

    always_comb begin
        grant     = '0;
        last_idx  = '0;
        any_grant = 1'b0;
        for (int l = 0; l < NCDB; l++) begin
            grant = grant | lane_onehot[l];
            if (lane_found[l]) begin
                last_idx  = lane_idx[l];
                any_grant = 1'b1;
            end
        end
        next_ptr = (last_idx == PTR_W'(NSRC-1)) ? '0 : last_idx + PTR_W'(1);
    end

    // Holding registers: a capture on the grant edge wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            hv <= '0;
            for (int i = 0; i < NSRC; i++) begin
                h_tag[i] <= '0;
                h_rob[i] <= '0;
                h_val[i] <= '0;
            end
        end else begin
            if (bus.squash) begin
                hv <= '0;
            end else begin
                hv <= capture | (hv & ~grant);
            end
            for (int i = 0; i < NSRC; i++) begin
                if (capture[i]) begin
                    h_tag[i] <= bus.fu_tag[i*PRF_IDX +: PRF_IDX];
                    h_rob[i] <= bus.fu_rob_idx[i*ROB_IDX +: ROB_IDX];
                    h_val[i] <= bus.fu_value[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Broadcast registers and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            cdb_valid_q <= '0;
            cdb_tag_q   <= '0;
            cdb_rob_q   <= '0;
            cdb_value_q <= '0;
            rr_ptr      <= '0;
        end else begin
            for (int l = 0; l < NCDB; l++) begin
                cdb_valid_q[l] <= lane_found[l];
                cdb_tag_q[l*PRF_IDX +: PRF_IDX] <= lane_found[l] ? h_tag[lane_idx[l]] : '0;
                cdb_rob_q[l*ROB_IDX +: ROB_IDX] <= lane_found[l] ? h_rob[lane_idx[l]] : '0;
                cdb_value_q[l*XLEN +: XLEN]     <= lane_found[l] ? h_val[lane_idx[l]] : '0;
            end
            if (any_grant) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    assign bus.fu_free     = fu_free;
    assign bus.cdb_valid   = cdb_valid_q;
    assign bus.cdb_tag     = cdb_tag_q;
    assign bus.cdb_rob_idx = cdb_rob_q;
    assign bus.cdb_value   = cdb_value_q;
    assign bus.rr_ptr      = rr_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random completions, checked
// against a queue-based round-robin reference model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NSRC   = 6;
  localparam int NCDB   = SCALAR;
  localparam int LANE_W = 1 + PRF_IDX + ROB_IDX + XLEN;
  localparam int REC_W  = NCDB * LANE_W;
  localparam int MAX_WAIT = (NSRC + NCDB - 1) / NCDB;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NSRC(NSRC), .NCDB(NCDB)) bus();

  cdb_arbiter #(.NSRC(NSRC), .NCDB(NCDB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // reference model state
  bit                 m_hv   [NSRC];
  logic [PRF_IDX-1:0] m_tag  [NSRC];
  logic [ROB_IDX-1:0] m_rob  [NSRC];
  logic [XLEN-1:0]    m_val  [NSRC];
  int                 m_wait [NSRC];
  int                 m_ptr;
  bit                 model_valid = 1'b0;

  logic [REC_W-1:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_idle();
    bus.fu_valid   = '0;
    bus.fu_tag     = '0;
    bus.fu_rob_idx = '0;
    bus.fu_value   = '0;
    bus.squash     = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [PRF_IDX-1:0] tag,
                         input logic [ROB_IDX-1:0] rob, input logic [XLEN-1:0] val);
    bus.fu_valid[i] = 1'b1;
    bus.fu_tag[i*PRF_IDX +: PRF_IDX]     = tag;
    bus.fu_rob_idx[i*ROB_IDX +: ROB_IDX] = rob;
    bus.fu_value[i*XLEN +: XLEN]         = val;
  endtask

  // One clock: check DUT against the model at the falling edge, advance the
  // model to its post-edge state, then return just after the rising edge.
  task automatic step();
    logic [NSRC-1:0]   m_grant;
    logic [NSRC-1:0]   exp_free;
    logic [REC_W-1:0]  rec;
    logic [REC_W-1:0]  got_rec;
    logic [LANE_W-1:0] e;
    int n, s, last;
    bit cap;
    @(negedge clk);
    m_grant = '0;
    rec     = '0;
    n       = 0;
    last    = -1;
    if (!bus.squash) begin
      for (int k = 0; k < NSRC; k++) begin
        s = (m_ptr + k) % NSRC;
        if (m_hv[s] && n < NCDB) begin
          m_grant[s] = 1'b1;
          rec[n*LANE_W +: LANE_W] = {1'b1, m_tag[s], m_rob[s], m_val[s]};
          n++;
          last = s;
        end
      end
    end
    for (int i = 0; i < NSRC; i++) exp_free[i] = !m_hv[i] || m_grant[i];

    if (model_valid) begin
      check_eq("fu_free", 64'(bus.fu_free), 64'(exp_free));
      check_eq("rr_ptr", 64'(bus.rr_ptr), 64'(m_ptr));
      for (int i = 0; i < NSRC; i++)
        if (m_grant[i]) check_eq("starve", 64'(m_wait[i] < MAX_WAIT), 64'd1);
    end
    if (exp_q.size() > 0) begin
      got_rec = exp_q.pop_front();
      for (int l = 0; l < NCDB; l++) begin
        e = got_rec[l*LANE_W +: LANE_W];
        check_eq("cdb_valid", 64'(bus.cdb_valid[l]), 64'(e[LANE_W-1]));
        check_eq("cdb_tag", 64'(bus.cdb_tag[l*PRF_IDX +: PRF_IDX]), 64'(e[XLEN+ROB_IDX +: PRF_IDX]));
        check_eq("cdb_rob", 64'(bus.cdb_rob_idx[l*ROB_IDX +: ROB_IDX]), 64'(e[XLEN +: ROB_IDX]));
        check_eq("cdb_value", bus.cdb_value[l*XLEN +: XLEN], e[XLEN-1:0]);
      end
    end

    if (reset) begin
      for (int i = 0; i < NSRC; i++) begin
        m_hv[i]   = 1'b0;
        m_wait[i] = 0;
      end
      m_ptr = 0;
      exp_q.push_back('0);
      model_valid = 1'b1;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        cap = bus.fu_valid[i] && exp_free[i] && !bus.squash;
        if (bus.squash) begin
          m_hv[i] = 1'b0;
          m_wait[i] = 0;
        end else if (cap) begin
          m_hv[i]   = 1'b1;
          m_wait[i] = 0;
          m_tag[i]  = bus.fu_tag[i*PRF_IDX +: PRF_IDX];
          m_rob[i]  = bus.fu_rob_idx[i*ROB_IDX +: ROB_IDX];
          m_val[i]  = bus.fu_value[i*XLEN +: XLEN];
        end else if (m_grant[i]) begin
          m_hv[i]   = 1'b0;
          m_wait[i] = 0;
        end else if (m_hv[i]) begin
          m_wait[i]++;
        end
      end
      if (last >= 0) m_ptr = (last + 1) % NSRC;
      exp_q.push_back(rec);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n);
    set_idle();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_eq("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    check_eq("rst_fu_free", 64'(bus.fu_free), 64'h3f);
    check_eq("rst_rr_ptr", 64'(bus.rr_ptr), 64'd0);
    idle_steps(1);

    // single completion: two-cycle latency, one cycle wide
    set_src(SRC_ALU0, 6'd5, 5'd3, 64'hAA);
    step();
    idle_steps(1);
    check_eq("lat_valid", 64'(bus.cdb_valid), 64'b01);
    check_eq("lat_tag", 64'(bus.cdb_tag[PRF_IDX-1:0]), 64'd5);
    check_eq("lat_rob", 64'(bus.cdb_rob_idx[ROB_IDX-1:0]), 64'd3);
    check_eq("lat_value", bus.cdb_value[XLEN-1:0], 64'hAA);
    idle_steps(1);
    check_eq("lat_pulse", 64'(bus.cdb_valid), 64'd0);

    // all six sources at once from rr_ptr 0
    do_reset();
    for (int i = 0; i < NSRC; i++) set_src(i, PRF_IDX'(10 + i), ROB_IDX'(i), 64'(100 + i));
    step();
    idle_steps(1);
    check_eq("all6_lane0_a", 64'(bus.cdb_tag[PRF_IDX-1:0]), 64'd10);
    check_eq("all6_lane1_a", 64'(bus.cdb_tag[2*PRF_IDX-1:PRF_IDX]), 64'd11);
    check_eq("all6_free", 64'(bus.fu_free), 64'b001111);
    idle_steps(1);
    check_eq("all6_lane0_b", 64'(bus.cdb_tag[PRF_IDX-1:0]), 64'd12);
    check_eq("all6_lane1_b", 64'(bus.cdb_tag[2*PRF_IDX-1:PRF_IDX]), 64'd13);
    idle_steps(1);
    check_eq("all6_lane0_c", 64'(bus.cdb_tag[PRF_IDX-1:0]), 64'd14);
    check_eq("all6_lane1_c", 64'(bus.cdb_tag[2*PRF_IDX-1:PRF_IDX]), 64'd15);
    idle_steps(2);

    // back-to-back completions from one source
    for (int t = 20; t <= 22; t++) begin
      set_idle();
      set_src(SRC_MULT0, PRF_IDX'(t), ROB_IDX'(t), 64'(t));
      step();
      check_eq("b2b_free", 64'(bus.fu_free[SRC_MULT0]), 64'd1);
    end
    idle_steps(3);

    // wrap from rr_ptr 4: source 5 then source 0
    set_src(SRC_MULT1, 6'd33, 5'd1, 64'h33);
    step();
    idle_steps(1);
    check_eq("wrap_ptr4", 64'(bus.rr_ptr), 64'd4);
    set_idle();
    set_src(SRC_ALU0, 6'd40, 5'd7, 64'h40);
    set_src(SRC_MEM1, 6'd45, 5'd9, 64'h45);
    step();
    step();
    check_eq("wrap_lane0", 64'(bus.cdb_tag[PRF_IDX-1:0]), 64'd45);
    check_eq("wrap_lane1", 64'(bus.cdb_tag[2*PRF_IDX-1:PRF_IDX]), 64'd40);
    check_eq("wrap_ptr1", 64'(bus.rr_ptr), 64'd1);
    step();
    idle_steps(4);

    // squash with six held entries
    for (int i = 0; i < NSRC; i++) set_src(i, PRF_IDX'(50 + i), ROB_IDX'(i), 64'(200 + i));
    step();
    set_idle();
    bus.squash = 1'b1;
    step();
    set_idle();
    check_eq("sq_valid", 64'(bus.cdb_valid), 64'd0);
    check_eq("sq_free", 64'(bus.fu_free), 64'h3f);
    idle_steps(4);

    // reset while entries held and both lanes broadcasting
    for (int i = 0; i < 5; i++) set_src(i, PRF_IDX'(60 + i), ROB_IDX'(i), 64'(300 + i));
    step();
    idle_steps(1);
    check_eq("rst_mid_busy", 64'(bus.cdb_valid), 64'b11);
    do_reset();
    check_eq("rst_mid_valid", 64'(bus.cdb_valid), 64'd0);
    check_eq("rst_mid_tag", 64'(bus.cdb_tag), 64'd0);
    check_eq("rst_mid_ptr", 64'(bus.rr_ptr), 64'd0);
    check_eq("rst_mid_free", 64'(bus.fu_free), 64'h3f);
    idle_steps(4);

    // random completions, squashes and resets
    for (int c = 0; c < 3000; c++) begin
      set_idle();
      for (int i = 0; i < NSRC; i++)
        if ($urandom_range(0, 99) < 45)
          set_src(i, PRF_IDX'($urandom), ROB_IDX'($urandom), {$urandom, $urandom});
      bus.squash = ($urandom_range(0, 39) == 0);
      reset      = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    idle_steps(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NSRC, default 6, number of FU completion sources (ALU0, ALU1, MULT0, MULT1, MEM0, MEM1, in index order).
REQ-002 Parameter NCDB, default `SCALAR (2), number of CDB lanes.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fu_valid  input  NSRC  completion request per source.
REQ-006 fu_tag  input  NSRC*`PRF_IDX  destination physical register per source.
REQ-007 fu_rob_idx  input  NSRC*`ROB_IDX  ROB entry per source.
REQ-008 fu_value  input  NSRC*64  result value per source.
REQ-009 squash  input  1  mispredict flush; discard all pending completions.
REQ-010 fu_free  output  NSRC  source may present a new completion this cycle; feeds exfu_free/multfu_free/memfu_free of the RS.
REQ-011 cdb_valid  output  NCDB  lane broadcast valid; feeds RS cdb_valid.
REQ-012 cdb_tag  output  NCDB*`PRF_IDX  broadcast tag; feeds RS cdb_tag.
REQ-013 cdb_rob_idx  output  NCDB*`ROB_IDX  ROB entry completed per lane.
REQ-014 cdb_value  output  NCDB*64  broadcast result per lane.

Function
REQ-015 Each source SHALL own a one-entry holding register {hv, tag, rob_idx, value}.
REQ-016 fu_free[i] SHALL equal ~hv[i] | grant[i] (combinational), allowing one completion per source per cycle.
REQ-017 On an edge with fu_valid[i] & fu_free[i] & ~squash, hold register i SHALL capture the request and set hv[i]; a request presented while fu_free[i]=0 SHALL be ignored (source must hold it).
REQ-018 Each cycle up to NCDB held entries SHALL be granted in round-robin order starting at pointer rr_ptr, wrapping from NSRC-1 to 0; first found goes to lane 0, second to lane 1.
REQ-019 Granted entries SHALL load the CDB output registers and cdb_valid SHALL be high for exactly the following cycle; ungranted lanes SHALL drive cdb_valid=0 and tag/rob/value 0.
REQ-020 Granted hv bits SHALL clear at the same edge unless a new capture on that source sets them (capture wins).
REQ-021 rr_ptr SHALL advance to (last granted index + 1) mod NSRC; with no grants it SHALL hold.
REQ-022 Latency: request accepted at edge E is broadcast no earlier than the cycle after edge E+1 (capture, then arbitrate/register); minimum 2 cycles fu_valid-to-cdb_valid.
REQ-023 With zero held entries all cdb_valid SHALL be 0; with exactly one, only lane 0 SHALL be valid.
REQ-024 squash SHALL at the next edge clear all hv, all cdb_valid, block captures that cycle, and leave rr_ptr unchanged; grant SHALL be forced 0 during squash.
REQ-025 No source SHALL wait more than ceil(NSRC/NCDB) arbitration cycles once held (starvation-free).
REQ-026 Two lanes SHALL never carry the same source in one cycle.

Reset
REQ-027 On reset: hv all 0, cdb_valid 0, cdb_tag/cdb_rob_idx/cdb_value 0, rr_ptr 0; fu_free all 1 in the cycle after reset.
REQ-028 Reset SHALL override squash and fu_valid; requests during reset are dropped.

Structure
REQ-029 `PRF_IDX, `ROB_IDX, `SCALAR and source-index constants SHALL come from the shared sys_defs header; no local redefinition.
REQ-030 A sub-module rr_pick (find-first-set from a start pointer over an NSRC mask, outputs one-hot and index, found flag) SHALL be instantiated NCDB times, later instances masking earlier winners.

Verification
REQ-031 After reset, fu_valid[0] with tag 5, rob 3, value 0xAA -> cdb_valid=2'b01, cdb_tag lane0=5, rob 3, value 0xAA two cycles later, one cycle wide.
REQ-032 All 6 sources valid same cycle (tags 10..15), rr_ptr=0 -> broadcasts {10,11}, {12,13}, {14,15} on three consecutive cycles; fu_free low for waiting sources.
REQ-033 Source 2 requests every cycle with tags 20,21,22 while alone -> one broadcast per cycle in order, fu_free[2] stays 1.
REQ-034 Six entries held, squash asserted -> next cycle cdb_valid=0, all fu_free=1, no held tag ever broadcast.
REQ-035 Sources 0 and 5 continuously valid, rr_ptr=4 -> lane0=5, lane1=0 (wrap), rr_ptr becomes 1.
REQ-036 Reset asserted while three entries held and cdb_valid=2'b11 -> next cycle all outputs 0, rr_ptr 0, no later broadcast of those tags.
